// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 2-flop input synchronizer and one-hot FSM.
// Ports: clk, rst_n (async, active-low), rx (serial in), data, rx_done, frame_err, busy.
module uart_rx #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 115_200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] data,
   output logic       rx_done,
   output logic       frame_err,
   output logic       busy
);

   localparam int N  = CLK_FREQ / BAUD_RATE;
   localparam int H  = N / 2;
   localparam int CW = $clog2(N);

   localparam logic [CW-1:0] N_M1 = CW'(N - 1);
   localparam logic [CW-1:0] H_M1 = CW'(H - 1);

   typedef enum logic [3:0] {
      IDLE  = 4'b0001,
      START = 4'b0010,
      RX    = 4'b0100,
      STOP  = 4'b1000
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shreg;
   logic          rx_m;
   logic          rx_s;
   logic          brk;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   assign busy = ~state[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shreg     <= '0;
         data      <= '0;
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
         brk       <= 1'b0;
      end else begin
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
         unique case (1'b1)
            state[0]: begin
               if (!rx_s) begin
                  state <= START;
                  cnt   <= '0;
               end
            end
            state[1]: begin
               if (cnt == H_M1) begin
                  cnt <= '0;
                  if (!rx_s) begin
                     state <= RX;
                     idx   <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            state[2]: begin
               if (cnt == N_M1) begin
                  shreg[idx] <= rx_s;
                  cnt        <= '0;
                  idx        <= idx + 1'b1;
                  if (idx == 3'd7)
                     state <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            state[3]: begin
               // Bad stop bit: park here, counter frozen,
               // until the line returns high.
               if (brk) begin
                  if (rx_s) begin
                     brk   <= 1'b0;
                     state <= IDLE;
                     cnt   <= '0;
                  end
               end else if (cnt == N_M1) begin
                  if (rx_s) begin
                     data    <= shreg;
                     rx_done <= 1'b1;
                     state   <= IDLE;
                     cnt     <= '0;
                  end else begin
                     frame_err <= 1'b1;
                     brk       <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               brk   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver: recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from the asynchronous `rx` line and presents each byte on a parallel port with a one-cycle strobe. It is the receive-side counterpart of `uart_tx`. It uses the same baud parameterisation and the same one-hot state encoding, so a `uart_tx` → `uart_rx` loopback works without glue logic.

## Interface
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 115_200: line rate in bit/s.
  - Derived: N = CLK_FREQ/BAUD_RATE clocks per bit (integer division), N ≥ 4.
  - Derived: H = N/2 (integer division).
- `clk`, input, 1: the single clock; all logic is on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `rx`, input, 1: serial line, idle high; asynchronous to `clk`.
- `data`, output, 8: last correctly framed byte; holds until the next good frame.
- `rx_done`, output, 1: one-cycle pulse when `data` has been updated.
- `frame_err`, output, 1: one-cycle pulse when the sampled stop bit is 0.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer, giving `rx_s`. Both flops reset to 1. The FSM uses only `rx_s`.
- One-hot states: IDLE=4'b0001, START=4'b0010, RX=4'b0100, STOP=4'b1000. They are held in the internal register `state`, which the bench probes.
- Internal registers:
  - `cnt`: baud counter, width clog2(N).
  - `idx`: bit index, 3 bits.
  - `shreg`: shift register, 8 bits.
- IDLE: when `rx_s`==0, go to START with `cnt`=0.
- START: `cnt` increments every cycle. At `cnt`==H-1 (mid start bit), sample `rx_s`:
  - 0: go to RX with `cnt`=0, `idx`=0.
  - 1: false start or glitch; return to IDLE with no pulse.
- RX: at `cnt`==N-1, set `shreg[idx]` = `rx_s`, set `cnt`=0, then `idx`++. After `idx`==7 is sampled, go to STOP.
- STOP: at `cnt`==N-1, sample `rx_s`:
  - 1: `data` ← `shreg`, pulse `rx_done`, go to IDLE.
  - 0: pulse `frame_err`, leave `data` unchanged. Stay in STOP with `cnt` frozen until `rx_s`==1, then go to IDLE. This prevents a held-low break from retriggering.
- Returning to IDLE at mid stop bit lets back-to-back frames be received with no gap.
- `rx_done` and `frame_err` are never high in the same cycle.

## Timing
- Reset values: `state`=IDLE, `data`=8'h00, `rx_done`=0, `frame_err`=0, `busy`=0, `cnt`=0, `idx`=0, `shreg`=0, sync flops=1.
- Reset applies immediately regardless of clock. Asserting it mid-frame abandons the frame with no pulse.
- Edge numbering: let edge k be the first clock edge at which `rx` is sampled low.
  - Edge k+2: START entered.
  - Edge k+2+H: RX entered.
  - Edge k+2+H+(i+1)·N: data bit i is sampled.
  - Edge k+2+H+9N: stop bit is sampled.
- Pulse timing: `rx_done`/`frame_err` are registered. They are high for exactly the one cycle after edge k+2+H+9N, so latency = 9N+H+2 cycles. For N=8 this is 78.
- `data` changes on the same edge that raises `rx_done` and is stable while it is high.
- `busy` rises with START and falls with the return to IDLE.
- Low pulses on `rx` shorter than H cycles produce no output. `busy` pulses high for H cycles only.

## Test plan
All scenarios use CLK_FREQ=50_000_000, BAUD_RATE=6_250_000 (N=8) and a 10 ns clock.
- **Reset:** hold `rst_n`=0 for 3 cycles with `rx`=1 → `state`=IDLE; `data`=0x00, `rx_done`=0, `frame_err`=0, `busy`=0.
- **Single frame:** drive frame 0x48 ('H') at 8 clocks/bit → `rx_done` pulses exactly once, 78 cycles after edge k. `data`=0x48; `state` passes START, RX, STOP, IDLE.
- **Back-to-back:** frames 0xA5 then 0x3C with no idle gap → two `rx_done` pulses 80 cycles apart. `data`=0xA5, then 0x3C; no `frame_err`.
- **Glitch:** `rx` low for 2 cycles → no `rx_done`; `state` returns to IDLE within H+3 cycles; `data` unchanged.
- **Framing error:** frame 0x55 with the stop bit at 0 and `rx` held low 20 more cycles → one `frame_err` pulse, no `rx_done`, `data` still 0x48. `state` stays STOP until `rx` goes high; a following frame 0x81 is then received correctly.
- **Reset mid-frame:** assert `rst_n` during data bit 3 → outputs go immediately to reset values. After release, frame 0x7E gives `data`=0x7E. Also run a `uart_tx` loopback of 0x00, 0xFF and 0x48 and check the bytes match.
